// File: rtl/pixel_row_pkg.sv
// Shared state encoding, default row width and index-width helper for the pixel row readout.
package pixel_row_pkg;

    localparam int PIXEL_ARRAY_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READOUT = 3'd4
    } row_state_e;

    // Width needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_column_adc.sv
// One pixel column: saturating exposure accumulator plus single-slope ramp-match latch.
module pixel_column_adc
    import pixel_row_pkg::*;
#(
    parameter int BIT_DEPTH   = 8,
    parameter int LIGHT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   accumulate,
    input  logic [LIGHT_WIDTH-1:0] light,
    input  logic [BIT_DEPTH-1:0]   ramp,
    input  logic                   convert,
    output logic [BIT_DEPTH-1:0]   value
);

    // One spare bit above the wider operand so the sum can never wrap before the clamp.
    localparam int SUM_W = ((BIT_DEPTH > LIGHT_WIDTH) ? BIT_DEPTH : LIGHT_WIDTH) + 1;
    localparam logic [SUM_W-1:0] SAT = SUM_W'({BIT_DEPTH{1'b1}});

    logic [BIT_DEPTH-1:0] acc_q, acc_d;
    logic [BIT_DEPTH-1:0] value_q, value_d;
    logic [SUM_W-1:0]     sum;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        acc_d   = acc_q;
        value_d = value_q;
        sum     = SUM_W'(acc_q) + SUM_W'(light);
        if (clear) begin
            acc_d   = '0;
            value_d = '0;
        end else if (accumulate) begin
            acc_d = (sum > SAT) ? BIT_DEPTH'(SAT) : BIT_DEPTH'(sum);
        end else if (convert && (ramp == acc_q)) begin
            value_d = ramp;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q   <= '0;
            value_q <= '0;
        end else begin
            acc_q   <= acc_d;
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pixel_row_readout.sv
// Pixel row sequencer (erase/expose/convert) with valid/ready column readout.
// Optional test pattern readout enabled by defining PIXEL_ROW_TEST_PATTERN_EN.
module pixel_row_readout
    import pixel_row_pkg::*;
#(
    parameter int ROW_WIDTH    = PIXEL_ARRAY_WIDTH,
    parameter int BIT_DEPTH    = 8,
    parameter int LIGHT_WIDTH  = 4,
    parameter int EXPOSE_WIDTH = 8,
    parameter int ERASE_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [EXPOSE_WIDTH-1:0]          expose_cycles,
    input  logic [ROW_WIDTH*LIGHT_WIDTH-1:0] light_in,
`ifdef PIXEL_ROW_TEST_PATTERN_EN
    input  logic                             test_mode,
`endif
    output logic                             busy,
    output logic                             erase,
    output logic                             expose,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BIT_DEPTH-1:0]             out_data,
    output logic [idx_width(ROW_WIDTH)-1:0]  out_col,
    output logic                             out_last
);

    localparam int COL_W = idx_width(ROW_WIDTH);
    localparam int ERS_W = idx_width(ERASE_CYCLES);
    localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(ROW_WIDTH - 1);
    localparam logic [ERS_W-1:0]     ERASE_LAST = ERS_W'(ERASE_CYCLES - 1);
    localparam logic [BIT_DEPTH-1:0] RAMP_LAST  = {BIT_DEPTH{1'b1}};

    row_state_e              state_q, state_d;
    logic [ERS_W-1:0]        erase_cnt_q, erase_cnt_d;
    logic [EXPOSE_WIDTH-1:0] expose_len_q, expose_len_d;
    logic [EXPOSE_WIDTH-1:0] expose_cnt_q, expose_cnt_d;
    logic [BIT_DEPTH-1:0]    ramp_q, ramp_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    pattern_sel;

    logic                    col_clear;
    logic                    col_accumulate;
    logic                    col_convert;
    logic [BIT_DEPTH-1:0]    col_value [ROW_WIDTH];

`ifdef PIXEL_ROW_TEST_PATTERN_EN
    logic test_q, test_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            test_q <= 1'b0;
        end else begin
            test_q <= test_d;
        end
    end

    always_comb begin
        test_d = test_q;
        if ((state_q == ST_IDLE) && start) begin
            test_d = test_mode;
        end
    end

    assign pattern_sel = test_q;
`else
    assign pattern_sel = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        erase_cnt_d    = erase_cnt_q;
        expose_len_d   = expose_len_q;
        expose_cnt_d   = expose_cnt_q;
        ramp_d         = ramp_q;
        col_d          = col_q;
        col_clear      = 1'b0;
        col_accumulate = 1'b0;
        col_convert    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ERASE;
                    expose_len_d = expose_cycles;
                    erase_cnt_d  = '0;
                end
            end
            ST_ERASE: begin
                col_clear = 1'b1;
                if (erase_cnt_q == ERASE_LAST) begin
                    expose_cnt_d = '0;
                    ramp_d       = '0;
                    state_d      = (expose_len_q == '0) ? ST_CONVERT : ST_EXPOSE;
                end else begin
                    erase_cnt_d = erase_cnt_q + 1'b1;
                end
            end
            ST_EXPOSE: begin
                col_accumulate = 1'b1;
                if (expose_cnt_q == expose_len_q - EXPOSE_WIDTH'(1)) begin
                    state_d = ST_CONVERT;
                end else begin
                    expose_cnt_d = expose_cnt_q + 1'b1;
                end
            end
            ST_CONVERT: begin
                col_convert = 1'b1;
                ramp_d      = ramp_q + 1'b1;
                if (ramp_q == RAMP_LAST) begin
                    state_d = ST_READOUT;
                    col_d   = '0;
                end
            end
            ST_READOUT: begin
                if (out_ready) begin
                    if (col_q == COL_LAST) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            erase_cnt_q  <= '0;
            expose_len_q <= '0;
            expose_cnt_q <= '0;
            ramp_q       <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            erase_cnt_q  <= erase_cnt_d;
            expose_len_q <= expose_len_d;
            expose_cnt_q <= expose_cnt_d;
            ramp_q       <= ramp_d;
            col_q        <= col_d;
        end
    end

    // NOTE: the per-column value registers are reset too, so out_data is 0 after reset rather than stale.
    for (genvar gi = 0; gi < ROW_WIDTH; gi++) begin : g_col
        pixel_column_adc #(
            .BIT_DEPTH   (BIT_DEPTH),
            .LIGHT_WIDTH (LIGHT_WIDTH)
        ) u_col (
            .clk        (clk),
            .reset      (reset),
            .clear      (col_clear),
            .accumulate (col_accumulate),
            .light      (light_in[gi*LIGHT_WIDTH +: LIGHT_WIDTH]),
            .ramp       (ramp_q),
            .convert    (col_convert),
            .value      (col_value[gi])
        );
    end

    assign busy      = (state_q != ST_IDLE);
    assign erase     = (state_q == ST_ERASE);
    assign expose    = (state_q == ST_EXPOSE);
    assign out_valid = (state_q == ST_READOUT);
    assign out_col   = col_q;
    assign out_last  = out_valid && (col_q == COL_LAST);
    assign out_data  = !out_valid ? '0 :
                       pattern_sel ? BIT_DEPTH'(col_q) : col_value[col_q];

endmodule

// File: tb/tb_pixel_row_readout.sv
// Scoreboard bench for pixel_row_readout: frames are predicted from light*exposure with clamping.
module tb_pixel_row_readout;

    localparam int RW   = 4;
    localparam int BD   = 8;
    localparam int LW   = 4;
    localparam int EW   = 8;
    localparam int EC   = 4;
    localparam int CW   = 2;
    localparam int MAXV = (1 << BD) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [EW-1:0]   expose_cycles;
    logic [RW*LW-1:0] light_in;
`ifdef PIXEL_ROW_TEST_PATTERN_EN
    logic            test_mode;
`endif
    logic            busy, erase, expose;
    logic            out_valid, out_ready, out_last;
    logic [BD-1:0]   out_data;
    logic [CW-1:0]   out_col;

    always #5 clk = ~clk;

    pixel_row_readout #(
        .ROW_WIDTH    (RW),
        .BIT_DEPTH    (BD),
        .LIGHT_WIDTH  (LW),
        .EXPOSE_WIDTH (EW),
        .ERASE_CYCLES (EC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expose_cycles (expose_cycles),
        .light_in      (light_in),
`ifdef PIXEL_ROW_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .busy          (busy),
        .erase         (erase),
        .expose        (expose),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_col       (out_col),
        .out_last      (out_last)
    );

    typedef struct {
        int data;
        int col;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [RW*LW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [RW*LW-1:0] v;
        v = '0;
        v[0*LW +: LW] = LW'(l0);
        v[1*LW +: LW] = LW'(l1);
        v[2*LW +: LW] = LW'(l2);
        v[3*LW +: LW] = LW'(l3);
        return v;
    endfunction

    // Reference: a column integrates a constant light level for ex cycles, clamped at full scale.
    task automatic predict(input logic [RW*LW-1:0] lt, input int ex, input logic tm);
        beat_t b;
        for (int i = 0; i < RW; i++) begin
            int raw;
            raw    = int'(lt[i*LW +: LW]) * ex;
            b.data = tm ? (i % (MAXV + 1)) : ((raw > MAXV) ? MAXV : raw);
            b.col  = i;
            b.last = (i == RW - 1) ? 1 : 0;
            exp_q.push_back(b);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
    initial begin
        int pat_idx;
        logic [3:0] pat;
        pat     = 4'b1001;
        pat_idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = pat[3 - pat_idx];
                    pat_idx   = (pat_idx + 1) % 4;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks hold/no-bubble behaviour.
    initial begin
        logic          pv, pr, pl;
        logic [BD-1:0] pd;
        logic [CW-1:0] pc;
        beat_t         b;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pc = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(pd));
                check("hold_col", 32'(out_col), 32'(pc));
                check("hold_last", 32'(out_last), 32'(pl));
            end
            if (pv && pr && !pl) begin
                check("no_bubble", 32'(out_valid), 1);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("out_data", 32'(out_data), b.data);
                    check("out_col", 32'(out_col), b.col);
                    check("out_last", 32'(out_last), b.last);
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pc = out_col; pl = out_last;
        end
    end

    task automatic wait_idle();
        int m;
        m = 0;
        while (busy && m < 5000) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("frame_done", 32'(busy), 0);
    endtask

    // Starts a frame; latency counts edges from the one sampling start to the one raising out_valid.
    task automatic run_frame(input logic [RW*LW-1:0] lt, input int ex, input logic tm, input logic pulse_start);
        int   n;
        logic seen_exp;
        @(posedge clk);
        #1;
        light_in      = lt;
        expose_cycles = EW'(ex);
        start         = 1'b1;
`ifdef PIXEL_ROW_TEST_PATTERN_EN
        test_mode     = tm;
`endif
        predict(lt, ex, tm);
        n        = 0;
        seen_exp = 1'b0;
        while (n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            start = pulse_start && (n == EC + ex + 60);
            if (expose) seen_exp = 1'b1;
            if (out_valid) break;
        end
        start = 1'b0;
        check("first_valid_latency", n, 1 + EC + ex + (1 << BD));
        if (ex == 0) check("expose_skipped", 32'(seen_exp), 0);
        wait_idle();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        expose_cycles = '0;
        light_in      = '0;
`ifdef PIXEL_ROW_TEST_PATTERN_EN
        test_mode     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_erase", 32'(erase), 0);
        check("rst_expose", 32'(expose), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_col", 32'(out_col), 0);
        check("rst_last", 32'(out_last), 0);
        reset = 1'b1;

        // Nominal frame with ready held high.
        ready_mode = 0;
        run_frame(pack4(1, 2, 3, 15), 10, 1'b0, 1'b0);

        // Saturation: 15*20 = 300 clamps to 255.
        run_frame(pack4(15, 0, 7, 15), 20, 1'b0, 1'b0);

        // Backpressure pattern on ready.
        ready_mode = 2;
        run_frame(pack4(4, 9, 11, 6), 13, 1'b0, 1'b0);

        // Zero exposure with a stray start during CONVERT.
        ready_mode = 0;
        run_frame(pack4(15, 15, 15, 15), 0, 1'b0, 1'b1);
        repeat (300) @(posedge clk);
        #1;
        check("no_second_frame", 32'(busy), 0);

        // Reset mid-CONVERT abandons the frame.
        @(posedge clk);
        #1;
        light_in      = pack4(5, 6, 7, 8);
        expose_cycles = EW'(5);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (EC + 5 + 100) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        repeat (300) @(posedge clk);
        #1;
        check("midrst_stays_idle", 32'(busy), 0);
        run_frame(pack4(3, 1, 4, 1), 7, 1'b0, 1'b0);

        // Randomised frames against the reference model.
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            run_frame(pack4($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15)),
                      $urandom_range(0, 40), 1'b0, 1'b0);
        end

`ifdef PIXEL_ROW_TEST_PATTERN_EN
        ready_mode = 0;
        run_frame(pack4(9, 9, 9, 9), 12, 1'b1, 1'b0);
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
